// File: rtl/alu_serial.sv
// alu_serial: slice-serial Z/N/H/C ALU, LSB slice first.
// Serves 8-bit accumulator and 16-bit pair arithmetic from one datapath.
module alu_serial #(
   parameter int WIDTH = 8,
   parameter int SLICE = 4,
   parameter int H_BIT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       flags_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags_out
);

   localparam int NS = WIDTH / SLICE;
   localparam int KW = (NS > 1) ? $clog2(NS) : 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_CP  = 3'd7;

   if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("alu_serial: WIDTH must be a multiple of SLICE");
   end
   if (((H_BIT + 1) % SLICE) != 0) begin : g_bad_hbit
      $error("alu_serial: H_BIT+1 must be a multiple of SLICE");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             cin_q, cin_d;
   logic [KW-1:0]    k_q, k_d;
   logic             zacc_q, zacc_d;
   logic             h_q, h_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic                   accept;
   logic                   is_sub;
   logic                   is_logic;
   logic [SLICE-1:0]       a_s;
   logic [SLICE-1:0]       b_s;
   logic [SLICE:0]         sum;
   logic [SLICE-1:0]       slice_res;
   logic                   cout;
   logic                   last;
   logic                   h_cap;
   logic                   z_fin;
   logic                   h_fin;
   logic [WIDTH+SLICE-1:0] sh_cat;

   assign in_ready  = (state_q == S_IDLE) ||
                      ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flags_out = flags_q;

   // one slice of the carry/borrow chain plus the bitwise ops
   always_comb begin
      is_sub    = (op_q == OP_SUB) || (op_q == OP_SBC) ||
                  (op_q == OP_CP);
      is_logic  = (op_q == OP_AND) || (op_q == OP_XOR) ||
                  (op_q == OP_OR);
      a_s       = a_q[k_q*SLICE +: SLICE];
      b_s       = b_q[k_q*SLICE +: SLICE];
      if (is_sub) begin
         sum = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, cin_q};
      end else begin
         sum = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, cin_q};
      end
      cout      = sum[SLICE];
      case (op_q)
         OP_AND:  slice_res = a_s & b_s;
         OP_XOR:  slice_res = a_s ^ b_s;
         OP_OR:   slice_res = a_s | b_s;
         default: slice_res = sum[SLICE-1:0];
      endcase
      sh_cat    = {slice_res, sh_q};
      last      = (k_q == KW'(NS - 1));
      h_cap     = ((int'(k_q) + 1) * SLICE - 1) == H_BIT;
      z_fin     = !(zacc_q || (slice_res != '0));
      case (op_q)
         OP_AND:        h_fin = 1'b1;
         OP_XOR, OP_OR: h_fin = 1'b0;
         default:       h_fin = h_cap ? cout : h_q;
      endcase
   end

   // next-state: accept, slice stepping, completion flags
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cin_d    = cin_q;
      k_d      = k_q;
      zacc_d   = zacc_q;
      h_d      = h_q;
      sh_d     = sh_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
         end
         S_RUN: begin
            cin_d  = is_logic ? 1'b0 : cout;
            sh_d   = sh_cat[WIDTH+SLICE-1:SLICE];
            zacc_d = zacc_q || (slice_res != '0);
            if (h_cap) h_d = cout;
            if (last) begin
               state_d  = S_DONE;
               k_d      = '0;
               result_d = (op_q == OP_CP) ? a_q : sh_d;
               flags_d  = {z_fin, is_sub, h_fin,
                           is_logic ? 1'b0 : cout};
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         state_d = S_RUN;
         a_d     = a;
         b_d     = b;
         op_d    = op;
         cin_d   = ((op == OP_ADC) || (op == OP_SBC)) && flags_in[0];
         k_d     = '0;
         zacc_d  = 1'b0;
         h_d     = 1'b0;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cin_q    <= 1'b0;
         k_q      <= '0;
         zacc_q   <= 1'b0;
         h_q      <= 1'b0;
         sh_q     <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cin_q    <= cin_d;
         k_q      <= k_d;
         zacc_q   <= zacc_d;
         h_q      <= h_d;
         sh_q     <= sh_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

endmodule
